// File: rtl/tone_generator.sv
// Square-wave tone generator: turns an (enable, frequency) request into a 50%-duty audio pin.
// Half-period comes from a 32-step sequential restoring divider; retunes land on toggle edges.
module tone_generator #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned MIN_FREQ = 20,
  parameter int unsigned MAX_FREQ = 20_000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic [15:0] iFreq,
  output logic        oAudio,
  output logic        oActive,
  output logic        oBusy
);

  typedef enum logic [1:0] {StIdle, StDiv, StRun} state_e;

  state_e      r_state,     w_state_nxt;
  logic [31:0] r_cnt,       w_cnt_nxt;
  logic [31:0] r_half,      w_half_nxt;
  logic [31:0] r_pending,   w_pending_nxt;
  logic        r_pend_vld,  w_pend_vld_nxt;
  logic [15:0] r_cur_freq,  w_cur_freq_nxt;
  logic [15:0] r_div_freq,  w_div_freq_nxt;
  logic        r_from_run,  w_from_run_nxt;
  logic [31:0] r_dvd,       w_dvd_nxt;
  logic [31:0] r_rem,       w_rem_nxt;
  logic [31:0] r_quo,       w_quo_nxt;
  logic [5:0]  r_step,      w_step_nxt;
  logic        r_audio,     w_audio_nxt;
  logic        r_active,    w_active_nxt;
  logic        r_busy,      w_busy_nxt;

  logic [15:0] w_req;
  logic        w_req_valid;
  logic        w_tick;
  logic [32:0] w_trial;
  logic [32:0] w_divisor;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_req       = iEnable ? iFreq : 16'd0;
  assign w_req_valid = ({16'd0, w_req} >= MIN_FREQ) && ({16'd0, w_req} <= MAX_FREQ);
  assign w_tick      = (r_cnt == r_half - 32'd1);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_trial   = {r_rem, r_dvd[31]};
  assign w_divisor = {16'd0, r_div_freq, 1'b0};
  assign w_diff    = w_trial - w_divisor;
  assign w_fits    = (w_trial >= w_divisor);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_half_nxt     = r_half;
    w_pending_nxt  = r_pending;
    w_pend_vld_nxt = r_pend_vld;
    w_cur_freq_nxt = r_cur_freq;
    w_div_freq_nxt = r_div_freq;
    w_from_run_nxt = r_from_run;
    w_dvd_nxt      = r_dvd;
    w_rem_nxt      = r_rem;
    w_quo_nxt      = r_quo;
    w_step_nxt     = r_step;
    w_audio_nxt    = r_audio;

    unique case (r_state)
      StIdle: begin
        w_audio_nxt = 1'b0;
        w_cnt_nxt   = 32'd0;
        if (w_req_valid) begin
          w_div_freq_nxt = w_req;
          w_from_run_nxt = 1'b0;
          w_dvd_nxt      = CLK_HZ;
          w_rem_nxt      = 32'd0;
          w_quo_nxt      = 32'd0;
          w_step_nxt     = 6'd0;
          w_state_nxt    = StDiv;
        end
      end

      StDiv: begin
        if (!w_req_valid) begin
          w_state_nxt    = StIdle;
          w_audio_nxt    = 1'b0;
          w_cnt_nxt      = 32'd0;
          w_pend_vld_nxt = 1'b0;
          w_from_run_nxt = 1'b0;
          w_cur_freq_nxt = 16'd0;
        end else begin
          // A retune keeps the old tone sounding while the divider works.
          if (r_from_run) begin
            if (w_tick) begin
              w_audio_nxt = ~r_audio;
              w_cnt_nxt   = 32'd0;
            end else begin
              w_cnt_nxt = r_cnt + 32'd1;
            end
          end
          if (r_step != 6'd32) begin
            w_rem_nxt  = w_fits ? w_diff[31:0] : w_trial[31:0];
            w_quo_nxt  = {r_quo[30:0], w_fits};
            w_dvd_nxt  = {r_dvd[30:0], 1'b0};
            w_step_nxt = r_step + 6'd1;
          end else begin
            w_cur_freq_nxt = r_div_freq;
            w_state_nxt    = StRun;
            w_from_run_nxt = 1'b0;
            if (r_from_run) begin
              w_pending_nxt  = r_quo;
              w_pend_vld_nxt = 1'b1;
            end else begin
              w_half_nxt  = r_quo;
              w_audio_nxt = 1'b1;
              w_cnt_nxt   = 32'd0;
            end
          end
        end
      end

      StRun: begin
        if (!w_req_valid) begin
          w_state_nxt    = StIdle;
          w_audio_nxt    = 1'b0;
          w_cnt_nxt      = 32'd0;
          w_pend_vld_nxt = 1'b0;
          w_cur_freq_nxt = 16'd0;
        end else begin
          if (w_tick) begin
            w_audio_nxt = ~r_audio;
            w_cnt_nxt   = 32'd0;
            if (r_pend_vld) begin
              w_half_nxt     = r_pending;
              w_pend_vld_nxt = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
          if ((w_req != r_cur_freq) && !r_pend_vld) begin
            w_div_freq_nxt = w_req;
            w_from_run_nxt = 1'b1;
            w_dvd_nxt      = CLK_HZ;
            w_rem_nxt      = 32'd0;
            w_quo_nxt      = 32'd0;
            w_step_nxt     = 6'd0;
            w_state_nxt    = StDiv;
          end
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_audio_nxt = 1'b0;
        w_cnt_nxt   = 32'd0;
      end
    endcase

    w_active_nxt = (w_state_nxt == StRun) || ((w_state_nxt == StDiv) && w_from_run_nxt);
    w_busy_nxt   = (w_state_nxt == StDiv);
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_state    <= StIdle;
      r_cnt      <= 32'd0;
      r_half     <= 32'd0;
      r_pending  <= 32'd0;
      r_pend_vld <= 1'b0;
      r_cur_freq <= 16'd0;
      r_div_freq <= 16'd0;
      r_from_run <= 1'b0;
      r_dvd      <= 32'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_step     <= 6'd0;
      r_audio    <= 1'b0;
      r_active   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_half     <= w_half_nxt;
      r_pending  <= w_pending_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_cur_freq <= w_cur_freq_nxt;
      r_div_freq <= w_div_freq_nxt;
      r_from_run <= w_from_run_nxt;
      r_dvd      <= w_dvd_nxt;
      r_rem      <= w_rem_nxt;
      r_quo      <= w_quo_nxt;
      r_step     <= w_step_nxt;
      r_audio    <= w_audio_nxt;
      r_active   <= w_active_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign oAudio  = r_audio;
  assign oActive = r_active;
  assign oBusy   = r_busy;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator, run with a 100 kHz clock so tone periods stay short.
module tb_tone_generator;

  localparam int unsigned ClkHz = 100_000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] freq;
  logic        audio;
  logic        active;
  logic        busy;

  int checks;
  int fails;

  tone_generator #(
    .CLK_HZ  (ClkHz),
    .MIN_FREQ(20),
    .MAX_FREQ(20_000)
  ) dut (
    .iClock (clk),
    .iReset (rst_n),
    .iEnable(en),
    .iFreq  (freq),
    .oAudio (audio),
    .oActive(active),
    .oBusy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until oAudio changes; 0 if it never does within the bound.
  task automatic measure_half(output int n);
    logic start;
    start = audio;
    n = 0;
    for (int i = 1; i <= 5000; i++) begin
      step();
      if (audio !== start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string name, input logic ea, input logic eact,
                               input logic eb);
    checks++;
    if ({audio, active, busy} !== {ea, eact, eb}) begin
      fails++;
      $display("FAIL %s: audio/active/busy = %b%b%b, expected %b%b%b", name, audio, active,
               busy, ea, eact, eb);
    end
  endtask

  // Request already applied; edge 0 is the next edge.
  task automatic check_latency(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i <= 32; i++) begin
      step();
      if (busy !== 1'b1 || audio !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s busy phase: %0d of 33 edges wrong, expected 0", name, bad);
    end
    step();
    check_outputs({name, " edge33"}, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_half(input string name, input int exp);
    int n;
    measure_half(n);
    checks++;
    if (n != exp) begin
      fails++;
      $display("FAIL %s: half period %0d edges, expected %0d", name, n, exp);
    end
  endtask

  task automatic hold_silent(input string name, input logic [15:0] f);
    int bad;
    freq = f;
    bad  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({audio, active, busy} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d of 40 edges non-silent, expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    freq  = 16'd440;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outputs("reset", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_start_150();
    rst_n = 1'b1;
    freq  = 16'd150;
    check_latency("start150");
    check_half("half150_a", 333);
    check_half("half150_b", 333);
  endtask

  task automatic test_retune();
    int n;
    freq = 16'd440;
    step();
    check_outputs("retune div", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step();
    check_outputs("retune pending", 1'b1, 1'b1, 1'b0);
    measure_half(n);
    checks++;
    if (n + 41 != 333) begin
      fails++;
      $display("FAIL retune old half: %0d edges, expected 333", n + 41);
    end
    check_half("half440_a", 113);
    check_half("half440_b", 113);
  endtask

  task automatic test_disable();
    for (int i = 0; i < 50; i++) step();
    en = 1'b0;
    step();
    check_outputs("disable", 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    check_latency("reenable");
    check_half("half440_re", 113);
  endtask

  task automatic test_range();
    hold_silent("freq10", 16'd10);
    hold_silent("freq25000", 16'd25000);
    hold_silent("freq19", 16'd19);
    hold_silent("freq20001", 16'd20001);
    freq = 16'd20000;
    check_latency("max20000");
    check_half("half20000_a", 2);
    check_half("half20000_b", 2);
    hold_silent("to_idle", 16'd0);
    freq = 16'd20;
    check_latency("min20");
    check_half("half20", 2500);
    en = 1'b0;
    step();
    check_outputs("min20 off", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    en   = 1'b1;
    freq = 16'd440;
    for (int i = 0; i < 10; i++) step();
    check_outputs("pre mid-div", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    check_outputs("reset mid-div", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_latency("after reset");
    check_half("half440_rst", 113);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_start_150();
    test_retune();
    test_disable();
    test_range();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
